// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encoding,
// OPDecoder class bit positions, branch funct3 values and halt causes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam int C_J   = 0;
    localparam int C_IJ  = 1;
    localparam int C_UL  = 2;
    localparam int C_UA  = 3;
    localparam int C_B   = 4;
    localparam int C_R   = 5;
    localparam int C_S   = 6;
    localparam int C_IA  = 7;
    localparam int C_IL  = 8;
    localparam int C_RSV = 9;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 of SRL/SRA and SRLI/SRAI, where bit 30 picks the arithmetic form.
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch outcome from funct3 and the rs1/rs2 comparator flags; funct3 values
// 010 and 011 have no branch meaning and are flagged illegal.
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       EQ,
    input  logic       LS,
    input  logic       LU,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = EQ;
            F3_BNE:  taken = !EQ;
            F3_BLT:  taken = LS;
            F3_BGE:  taken = !LS;
            F3_BLTU: taken = LU;
            F3_BGEU: taken = !LU;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with a
// bus-timeout watchdog, illegal-instruction halt and retired-instruction count.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      INSN,
    input  logic [9:0]       Code,
    input  logic             EQ,
    input  logic             LS,
    input  logic             LU,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_next_sel,
    output logic             pc_alu_sel,
    output logic             sub_sra,
    output logic             rd_we,
    output logic             pc_we,
    output logic             retired,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       err_code
);

    localparam logic [7:0] TIMEOUT_CYCLES = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [9:0]       code_q, code_d;
    logic             taken_q, taken_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    err_e             err_q, err_d;

    logic [2:0] funct3;
    logic       bc_taken;
    logic       bc_illegal;
    logic       decode_illegal;
    logic       wait_expired;
    logic       unused_insn;

    assign funct3      = INSN[14:12];
    assign unused_insn = ^{INSN[31], INSN[29:15], INSN[11:0]};

    branch_cond u_branch_cond (
        .funct3  (funct3),
        .EQ      (EQ),
        .LS      (LS),
        .LU      (LU),
        .taken   (bc_taken),
        .illegal (bc_illegal)
    );

    assign decode_illegal = !is_onehot10(Code) || Code[C_RSV] || (Code[C_B] && bc_illegal);
    assign wait_expired   = (wait_q + 8'd1) == TIMEOUT_CYCLES;

    // The wait counter is zeroed on every transition so each memory state starts fresh.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        taken_d   = taken_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        err_d     = err_q;
        case (state_q)
            ST_FETCH, ST_MEM: begin
                if (mem_ready) begin
                    state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_WB;
                    wait_d  = 8'd0;
                end else if (wait_expired) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                    wait_d  = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                code_d = Code;
                if (decode_illegal) begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                taken_d = bc_taken;
                state_d = (code_q[C_IL] || code_q[C_S]) ? ST_MEM : ST_WB;
            end
            ST_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FETCH;
            code_q    <= 10'd0;
            taken_q   <= 1'b0;
            wait_q    <= 8'd0;
            instret_q <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            taken_q   <= taken_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode the registered state; reset forces them low at once so an
    // in-flight memory request is dropped without waiting for a clock edge.
    always_comb begin
        ir_we       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        pc_next_sel = 1'b0;
        pc_alu_sel  = 1'b0;
        sub_sra     = 1'b0;
        rd_we       = 1'b0;
        pc_we       = 1'b0;
        retired     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                pc_alu_sel = code_q[C_J] || code_q[C_UA] || code_q[C_B];
                if (code_q[C_R]) begin
                    sub_sra = INSN[30];
                end else if (code_q[C_IA] && (funct3 == F3_SR)) begin
                    sub_sra = INSN[30];
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = code_q[C_S];
            end
            ST_WB: begin
                pc_we       = 1'b1;
                retired     = 1'b1;
                rd_we       = !(code_q[C_B] || code_q[C_S]);
                pc_next_sel = code_q[C_J] || code_q[C_IJ] || (code_q[C_B] && taken_q);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
        if (!RST_N) begin
            ir_we       = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            addr_sel    = 1'b0;
            pc_next_sel = 1'b0;
            pc_alu_sel  = 1'b0;
            sub_sra     = 1'b0;
            rd_we       = 1'b0;
            pc_we       = 1'b0;
            retired     = 1'b0;
            halted      = 1'b0;
        end
    end

    assign instret  = instret_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors for each
// instruction class, illegal/timeout halts and asynchronous reset.
module tb_multicycle_ctrl;

    localparam logic [10:0] O_IRWE = 11'b100_0000_0000;
    localparam logic [10:0] O_MREQ = 11'b010_0000_0000;
    localparam logic [10:0] O_MWE  = 11'b001_0000_0000;
    localparam logic [10:0] O_ADDR = 11'b000_1000_0000;
    localparam logic [10:0] O_PCNX = 11'b000_0100_0000;
    localparam logic [10:0] O_ALUA = 11'b000_0010_0000;
    localparam logic [10:0] O_SUB  = 11'b000_0001_0000;
    localparam logic [10:0] O_RDWE = 11'b000_0000_1000;
    localparam logic [10:0] O_PCWE = 11'b000_0000_0100;
    localparam logic [10:0] O_RET  = 11'b000_0000_0010;
    localparam logic [10:0] O_HALT = 11'b000_0000_0001;
    localparam logic [10:0] O_NONE = 11'b000_0000_0000;

    logic        CLK;
    logic        RST_N;
    logic [31:0] INSN;
    logic [9:0]  Code;
    logic        EQ, LS, LU;
    logic        memReady;
    logic        ir_we, mem_req, mem_we, addr_sel, pc_next_sel, pc_alu_sel;
    logic        sub_sra, rd_we, pc_we, retired, halted;
    logic [31:0] instret;
    logic [1:0]  err_code;

    int compareCount = 0;
    int failCount    = 0;
    int retiredExp   = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .INSN        (INSN),
        .Code        (Code),
        .EQ          (EQ),
        .LS          (LS),
        .LU          (LU),
        .mem_ready   (memReady),
        .ir_we       (ir_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .pc_next_sel (pc_next_sel),
        .pc_alu_sel  (pc_alu_sel),
        .sub_sra     (sub_sra),
        .rd_we       (rd_we),
        .pc_we       (pc_we),
        .retired     (retired),
        .instret     (instret),
        .halted      (halted),
        .err_code    (err_code)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mkInsn(input logic b30, input logic [2:0] f3);
        return {1'b0, b30, 15'd0, f3, 12'd0};
    endfunction

    function automatic logic [10:0] outs();
        return {ir_we, mem_req, mem_we, addr_sel, pc_next_sel, pc_alu_sel,
                sub_sra, rd_we, pc_we, retired, halted};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] code, input logic [31:0] insn,
                                 input logic eq, input logic lu, input logic ready);
        Code     = code;
        INSN     = insn;
        EQ       = eq;
        LS       = 1'b0;
        LU       = lu;
        memReady = ready;
    endtask

    // Called at posedge+1: settle, check this cycle's outputs, move to the next cycle.
    task automatic cycleCheck(input string tag, input logic [10:0] exp);
        #1;
        checkOutput(tag, {21'd0, outs()}, {21'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        #1;
        @(posedge CLK);
        #1;
        RST_N      = 1'b1;
        retiredExp = 0;
    endtask

    task automatic runInsn(input string tag, input logic [9:0] code, input logic [31:0] insn,
                           input logic eq, input logic lu, input logic [10:0] expExec,
                           input int memWaits, input logic [10:0] expMem, input logic [10:0] expWb);
        applyStimulus(code, insn, eq, lu, 1'b1);
        cycleCheck({tag, "_fetch"}, O_IRWE | O_MREQ);
        cycleCheck({tag, "_decode"}, O_NONE);
        cycleCheck({tag, "_exec"}, expExec);
        if (expMem != O_NONE) begin
            for (int i = 0; i < memWaits; i++) begin
                memReady = 1'b0;
                cycleCheck({tag, "_memwait"}, expMem);
            end
            memReady = 1'b1;
            cycleCheck({tag, "_memack"}, expMem);
        end
        cycleCheck({tag, "_wb"}, expWb);
        retiredExp++;
        checkOutput({tag, "_instret"}, instret, retiredExp);
    endtask

    task automatic runIllegal(input string tag, input logic [9:0] code, input logic [31:0] insn);
        doReset();
        applyStimulus(code, insn, 1'b0, 1'b0, 1'b1);
        cycleCheck({tag, "_fetch"}, O_IRWE | O_MREQ);
        cycleCheck({tag, "_decode"}, O_NONE);
        for (int i = 0; i < 3; i++) begin
            cycleCheck({tag, "_halt"}, O_HALT);
        end
        checkOutput({tag, "_err"}, {30'd0, err_code}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N = 1'b0;
        applyStimulus(10'h020, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("reset_outs", {21'd0, outs()}, 32'd0);
        checkOutput("reset_instret", instret, 32'd0);
        checkOutput("reset_err", {30'd0, err_code}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        runInsn("add",   10'h020, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_NONE,        0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("bne_t", 10'h010, mkInsn(1'b0, 3'b001), 1'b0, 1'b0, O_ALUA,        0, O_NONE, O_PCWE | O_RET | O_PCNX);
        runInsn("bne_n", 10'h010, mkInsn(1'b0, 3'b001), 1'b1, 1'b0, O_ALUA,        0, O_NONE, O_PCWE | O_RET);
        runInsn("sw",    10'h040, mkInsn(1'b0, 3'b010), 1'b0, 1'b0, O_NONE,        3, O_MREQ | O_MWE | O_ADDR, O_PCWE | O_RET);
        runInsn("sub",   10'h020, mkInsn(1'b1, 3'b000), 1'b0, 1'b0, O_SUB,         0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("bltu",  10'h010, mkInsn(1'b0, 3'b110), 1'b0, 1'b1, O_ALUA,        0, O_NONE, O_PCWE | O_RET | O_PCNX);
        runInsn("bgeu",  10'h010, mkInsn(1'b0, 3'b111), 1'b0, 1'b1, O_ALUA,        0, O_NONE, O_PCWE | O_RET);
        runInsn("jal",   10'h001, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_ALUA,        0, O_NONE, O_RDWE | O_PCWE | O_RET | O_PCNX);
        runInsn("jalr",  10'h002, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_NONE,        0, O_NONE, O_RDWE | O_PCWE | O_RET | O_PCNX);
        runInsn("lui",   10'h004, mkInsn(1'b1, 3'b101), 1'b0, 1'b0, O_NONE,        0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("auipc", 10'h008, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_ALUA,        0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("srai",  10'h080, mkInsn(1'b1, 3'b101), 1'b0, 1'b0, O_SUB,         0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("addi",  10'h080, mkInsn(1'b1, 3'b000), 1'b0, 1'b0, O_NONE,        0, O_NONE, O_RDWE | O_PCWE | O_RET);
        runInsn("lw",    10'h100, mkInsn(1'b0, 3'b010), 1'b0, 1'b0, O_NONE,        1, O_MREQ | O_ADDR, O_RDWE | O_PCWE | O_RET);

        runIllegal("ill_rsv",    10'h200, mkInsn(1'b0, 3'b000));
        runIllegal("ill_multi",  10'h003, mkInsn(1'b0, 3'b000));
        runIllegal("ill_bf3",    10'h010, mkInsn(1'b0, 3'b010));

        doReset();
        applyStimulus(10'h020, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycleCheck("tmo_wait", O_MREQ);
        end
        cycleCheck("tmo_halt", O_HALT);
        checkOutput("tmo_err", {30'd0, err_code}, 32'd2);
        memReady = 1'b1;
        cycleCheck("tmo_stay", O_HALT);

        doReset();
        runInsn("pre_add", 10'h020, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_NONE, 0, O_NONE, O_RDWE | O_PCWE | O_RET);
        applyStimulus(10'h100, mkInsn(1'b0, 3'b010), 1'b0, 1'b0, 1'b1);
        cycleCheck("rst_fetch", O_IRWE | O_MREQ);
        cycleCheck("rst_decode", O_NONE);
        cycleCheck("rst_exec", O_NONE);
        memReady = 1'b0;
        #1;
        checkOutput("rst_inmem", {21'd0, outs()}, {21'd0, O_MREQ | O_ADDR});
        #1;
        RST_N = 1'b0;
        #1;
        checkOutput("rst_async_outs", {21'd0, outs()}, 32'd0);
        checkOutput("rst_async_instret", instret, 32'd0);
        @(posedge CLK);
        #1;
        RST_N      = 1'b1;
        retiredExp = 0;
        runInsn("post_add", 10'h020, mkInsn(1'b0, 3'b000), 1'b0, 1'b0, O_NONE, 0, O_NONE, O_RDWE | O_PCWE | O_RET);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
